mux_arbiter: RTL and testbench
==============================

# mux_arbiter

Two-requester arbiter and sequencer for the sorter's shared 8-bit 2:1 data mux. Two upstream streams (A, B) compete for one downstream path into the sorter. The block picks a winner each cycle, drives the mux select, and registers the selected byte behind a valid/ready handshake. It also counts completed output transfers for debug.

## Interface
- `WIDTH`, default 8: data width of both sources and the output.
- `CNT_W`, default 16: width of the transfer counter.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `a_valid` in 1: source A has data.
- `a_data` in WIDTH: source A byte.
- `a_ready` out 1: source A byte accepted this cycle.
- `b_valid` in 1: source B has data.
- `b_data` in WIDTH: source B byte.
- `b_ready` out 1: source B byte accepted this cycle.
- `out_valid` out 1: `out_data` holds a byte.
- `out_data` out WIDTH: registered selected byte.
- `out_ready` in 1: downstream accepts `out_data`.
- `sel` out 1: mux select; 0 = A, 1 = B. Identifies the source of the current or last `out_data`.
- `xfer_cnt` out CNT_W: count of output handshakes.

## Operation
States:
- IDLE: `out_valid` = 0.
- BUSY_A: holding a byte from A; `out_valid` = 1, `sel` = 0.
- BUSY_B: holding a byte from B; `out_valid` = 1, `sel` = 1.

Load and grant rules:
- `load = (state == IDLE) || out_ready`, i.e. the register is empty or draining this cycle.
- Winner, when `load`:
  - Only A valid → A wins. Only B valid → B wins.
  - Both valid → the source not granted last time wins (round-robin, see Configuration).
- `a_ready = load && winner == A`; `b_ready = load && winner == B`. Both are combinational.
- Never both ready in one cycle.
- On `load` with a winner: capture the winner's data into `out_data`, go to BUSY_A/BUSY_B, and update `last_grant`.
- On `load` with no request: go to IDLE. `out_data` holds its value; `sel` holds the last winner.
- No `load` (BUSY and `!out_ready`): state, `out_data` and `sel` are frozen, and both readies are 0.

Transfer counter:
- `xfer_cnt` increments when `out_valid && out_ready`.
- It wraps from 2^CNT_W−1 to 0.

## Timing
Reset (synchronous) values:
- State IDLE, `out_valid` 0, `out_data` 0, `sel` 0, `last_grant` B (so A wins the first tie), `xfer_cnt` 0.
- `a_ready` and `b_ready` are 0 while `rst` is high.
- Reset mid-transfer drops the held byte with no handshake, and the counter clears.

Latency and throughput:
- Latency is 1 cycle: a byte accepted in cycle N appears with `out_valid` in N+1.
- Full throughput is 1 byte/cycle when `out_ready` is held high.

Boundary behaviour:
- Simultaneous drain and load (BUSY, `out_ready` = 1, a request present): the old byte is handed off and the new byte is captured in the same edge, with no bubble.
- Backpressure: while `out_ready` = 0 in BUSY, `out_data` and `sel` are stable and no source is acknowledged.
- `sel` changes only on a `load` with a winner.
- A request that drops without seeing its ready is not captured.

## Configuration
- `MUX_ARBITER_RR_EN` defined: round-robin tie-break using `last_grant`, as described above.
- `MUX_ARBITER_RR_EN` undefined: fixed priority, A always wins ties. The `last_grant` register is not built. B is granted only when A is not valid.
- All other behaviour is identical in both builds.

## Test plan
- Reset check: assert `rst` for 2 cycles with both sources valid → `a_ready`/`b_ready` = 0, `out_valid` = 0, `sel` = 0, `xfer_cnt` = 0.
- Single source: A sends 0x11, 0x22, 0x33 back-to-back with `out_ready` = 1 → `out_data` shows 0x11, 0x22, 0x33 on cycles 1–3 after acceptance, `sel` = 0, `xfer_cnt` = 3.
- Tie, RR build:
  - Stimulus: A holds 0xA0..0xA2 and B holds 0xB0..0xB2, both valid, `out_ready` = 1.
  - Required output: 0xA0, 0xB0, 0xA1, 0xB1, 0xA2, 0xB2, with `sel` toggling 0,1,0,1,0,1.
  - Non-RR build, same stimulus: A drains first, then B.
- Backpressure: BUSY_B holding 0x5C, `out_ready` = 0 for 4 cycles, A valid → `out_data` = 0x5C and `sel` = 1 are stable, `a_ready` = 0 throughout. On `out_ready` = 1, A's byte loads the same cycle.
- Counter wrap: preload the count by running 65535 transfers, then 2 more → `xfer_cnt` reads 0xFFFF, 0x0000, 0x0001.
- Mid-operation reset: BUSY_A with 0x7E stalled, pulse `rst` for 1 cycle → next cycle IDLE, `out_valid` = 0, `out_data` = 0, no handshake counted.

Source files
------------

// File: rtl/mux_arbiter.sv
// Two-source arbiter feeding a registered 2:1 byte mux with valid/ready output and a transfer counter.
// Optional build macro: MUX_ARBITER_RR_EN selects round-robin tie-break; otherwise A wins ties.
module mux_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_A = 2'd1,
        ST_BUSY_B = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_data;
    logic             r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load;
    logic             w_tie_a;
    logic             w_win_a;
    logic             w_win_b;

`ifdef MUX_ARBITER_RR_EN
    logic             r_last_grant_b;

    // Remember the last winner so the other source takes the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant_b <= 1'b1;
        end else if (w_load && (w_win_a || w_win_b)) begin
            r_last_grant_b <= w_win_b;
        end else begin
            r_last_grant_b <= r_last_grant_b;
        end
    end

    assign w_tie_a = r_last_grant_b;
`else
    assign w_tie_a = 1'b1;
`endif

    // Winner selection and next-state decode; the register can refill while draining.
    always_comb begin
        w_load       = 1'b0;
        w_win_a      = 1'b0;
        w_win_b      = 1'b0;
        w_next_state = r_state;
        if (r_state == ST_IDLE) begin
            w_load = 1'b1;
        end else begin
            w_load = out_ready;
        end
        w_win_a = a_valid && (!b_valid || w_tie_a);
        w_win_b = b_valid && !w_win_a;
        case (r_state)
            ST_IDLE, ST_BUSY_A, ST_BUSY_B: begin
                if (!w_load) begin
                    w_next_state = r_state;
                end else if (w_win_a) begin
                    w_next_state = ST_BUSY_A;
                end else if (w_win_b) begin
                    w_next_state = ST_BUSY_B;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the winning byte and its source on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= {WIDTH{1'b0}};
            r_sel  <= 1'b0;
        end else if (w_load && w_win_a) begin
            r_data <= a_data;
            r_sel  <= 1'b0;
        end else if (w_load && w_win_b) begin
            r_data <= b_data;
            r_sel  <= 1'b1;
        end else begin
            r_data <= r_data;
            r_sel  <= r_sel;
        end
    end

    // Count completed output handshakes, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state != ST_IDLE) && out_ready) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign a_ready   = !rst && w_load && w_win_a;
    assign b_ready   = !rst && w_load && w_win_b;
    assign out_valid = (r_state != ST_IDLE);
    assign out_data  = r_data;
    assign sel       = r_sel;
    assign xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_mux_arbiter.sv
// Randomized and directed bench for mux_arbiter, checked against a transaction-level reference model.
module tb_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid, a_ready, b_ready;
    logic [7:0] a_data, b_data, out_data;
    logic       out_valid, out_ready, sel;
    logic [15:0] xfer_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the output slot and what it holds.
    bit          m_full;
    bit [7:0]    m_byte;
    bit          m_src_b;
    bit          m_prefer_b;
    int unsigned m_count;

    always #5 clk = ~clk;

    mux_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel), .xfer_cnt(xfer_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive, check readies, clock, check outputs against the model.
    task automatic step(input bit r, input bit av, input bit [7:0] ad,
                        input bit bv, input bit [7:0] bd, input bit ordy,
                        output bit took_a, output bit took_b);
        bit room;
        @(negedge clk);
        rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
        #1;
        room   = !m_full || ordy;
        took_a = 1'b0;
        took_b = 1'b0;
        if (!r && room) begin
            if (av && bv) begin
`ifdef MUX_ARBITER_RR_EN
                took_b = m_prefer_b;
`endif
                took_a = !took_b;
            end else begin
                took_a = av;
                took_b = bv;
            end
        end
        chk("a_ready", a_ready, took_a);
        chk("b_ready", b_ready, took_b);
        @(posedge clk);
        if (r) begin
            m_full = 0; m_byte = 0; m_src_b = 0; m_prefer_b = 0; m_count = 0;
        end else begin
            if (m_full && ordy) m_count = (m_count + 1) % 65536;
            if (room) begin
                m_full = took_a || took_b;
                if (took_a) begin m_byte = ad; m_src_b = 0; m_prefer_b = 1; end
                if (took_b) begin m_byte = bd; m_src_b = 1; m_prefer_b = 0; end
            end
        end
        #1;
        chk("out_valid", out_valid, m_full);
        chk("out_data", out_data, m_byte);
        chk("sel", sel, m_src_b);
        chk("xfer_cnt", xfer_cnt, m_count);
    endtask

    initial begin
        bit ta, tb;
        int ai, bi, guard;
        bit [7:0] seq_a [3];
        rst = 1; a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; out_ready = 0;
        m_full = 0; m_byte = 0; m_src_b = 0; m_prefer_b = 0; m_count = 0;

        // Reset with both sources requesting.
        step(1, 1, 8'h12, 1, 8'h34, 1, ta, tb);
        step(1, 1, 8'h12, 1, 8'h34, 1, ta, tb);
        chk("rst_cnt", xfer_cnt, 0);

        // Single source A, back-to-back.
        seq_a = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            step(0, 1, seq_a[i], 0, 8'h00, 1, ta, tb);
            chk("single_data", out_data, seq_a[i]);
        end
        step(0, 0, 8'h00, 0, 8'h00, 1, ta, tb);
        chk("single_cnt", xfer_cnt, 3);

        // Tie: each source holds its next byte until accepted.
        ai = 0; bi = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, ai < 3, 8'hA0 + 8'(ai), bi < 3, 8'hB0 + 8'(bi), 1, ta, tb);
            if (ta) ai++;
            if (tb) bi++;
        end
        chk("tie_drained_a", ai, 3);
        chk("tie_drained_b", bi, 3);

        // Backpressure in BUSY_B, then release with A waiting.
        step(0, 0, 8'h00, 1, 8'h5C, 1, ta, tb);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h66, 0, 8'h00, 0, ta, tb);
            chk("bp_data", out_data, 8'h5C);
        end
        step(0, 1, 8'h66, 0, 8'h00, 1, ta, tb);
        chk("bp_release", out_data, 8'h66);

        // Mid-operation reset while stalled.
        step(0, 1, 8'h7E, 0, 8'h00, 1, ta, tb);
        step(0, 0, 8'h00, 0, 8'h00, 0, ta, tb);
        step(1, 0, 8'h00, 0, 8'h00, 0, ta, tb);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        step(0, 0, 8'h00, 0, 8'h00, 1, ta, tb);
        chk("midrst_cnt", xfer_cnt, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), $urandom_range(0, 1), 8'($urandom),
                 $urandom_range(0, 1), 8'($urandom), ($urandom_range(0, 3) != 0), ta, tb);
        end

        // Counter wrap: reset, then stream until the count reaches its maximum.
        step(1, 0, 8'h00, 0, 8'h00, 0, ta, tb);
        guard = 0;
        while (m_count != 65535 && guard < 70000) begin
            step(0, 1, 8'(guard), 0, 8'h00, 1, ta, tb);
            guard++;
        end
        chk("wrap_ffff", xfer_cnt, 16'hFFFF);
        step(0, 1, 8'h01, 0, 8'h00, 1, ta, tb);
        chk("wrap_0000", xfer_cnt, 16'h0000);
        step(0, 1, 8'h02, 0, 8'h00, 1, ta, tb);
        chk("wrap_0001", xfer_cnt, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
